// File: rtl/mbinit_pkg.sv
// Shared MBINIT sideband message codes and the REPAIRCLK partner state encoding.
// The TIMEOUT state exists only when REPAIRCLK_TIMEOUT_EN is defined.
package mbinit_pkg;

  localparam logic [3:0] INIT_REQ    = 4'h1;
  localparam logic [3:0] INIT_RESP   = 4'h2;
  localparam logic [3:0] RESULT_REQ  = 4'h3;
  localparam logic [3:0] RESULT_RESP = 4'h4;
  localparam logic [3:0] DONE_REQ    = 4'h5;
  localparam logic [3:0] DONE_RESP   = 4'h6;

  localparam int NUM_LANES = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_INIT_REQ,
    ST_HOLD_INIT,
    ST_INIT_RESP,
    ST_DETECT,
    ST_HOLD_RESULT,
    ST_RESULT_RESP,
    ST_WAIT_DONE_REQ,
    ST_HOLD_DONE,
    ST_DONE_RESP,
    ST_DONE
`ifdef REPAIRCLK_TIMEOUT_EN
    , ST_TIMEOUT
`endif
  } repairclk_state_e;

  // Message driven on the sideband while sitting in a response state; zero elsewhere.
  function automatic logic [3:0] resp_code(input repairclk_state_e st);
    logic [3:0] code;
    code = 4'h0;
    case (st)
      ST_INIT_RESP:   code = INIT_RESP;
      ST_RESULT_RESP: code = RESULT_RESP;
      ST_DONE_RESP:   code = DONE_RESP;
      default:        code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic is_resp_state(input repairclk_state_e st);
    return (st == ST_INIT_RESP) || (st == ST_RESULT_RESP) || (st == ST_DONE_RESP);
  endfunction

endpackage

// File: rtl/repairclk_lane_counter.sv
// Per-lane consecutive clock-pattern counter; pass once PASS_THRESHOLD good
// iterations are seen in a row, after which misses no longer disturb it.
module repairclk_lane_counter #(
  parameter int PASS_THRESHOLD = 16
) (
  input  logic CLK,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  input  logic hit,
  input  logic miss,
  output logic pass
);

  localparam logic [4:0] THRESHOLD = 5'(PASS_THRESHOLD);

  logic [4:0] count_q;
  logic [4:0] count_d;

  // A miss wins over a simultaneous hit, but a lane that already reached the
  // threshold keeps its pass result.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 5'd0;
    end else if (count_en) begin
      if (miss) begin
        if (count_q != THRESHOLD) begin
          count_d = 5'd0;
        end
      end else if (hit && (count_q < THRESHOLD)) begin
        count_d = count_q + 5'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      count_q <= 5'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign pass = (count_q == THRESHOLD);

endmodule

// File: rtl/repairclk_module_partner.sv
// MBINIT REPAIRCLK module-partner responder: answers INIT/RESULT/DONE requests
// and reports per-lane clock-pattern results. Optional watchdog: REPAIRCLK_TIMEOUT_EN.
module repairclk_module_partner
  import mbinit_pkg::*;
#(
  parameter int PASS_THRESHOLD = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       i_MBINIT_CAL_end,
  input  logic [3:0] i_RX_SbMessage,
  input  logic       i_Busy_SideBand,
  input  logic       i_falling_edge_busy,
  input  logic [2:0] i_pattern_hit,
  input  logic [2:0] i_pattern_miss,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_ValidOutData_ModulePartner,
  output logic [2:0] o_msginfo,
  output logic       o_detector_en,
  output logic       o_MBINIT_REPAIRCLK_ModulePartner_end,
  output logic       o_timeout
);

  repairclk_state_e state_q, state_d;

  logic [3:0] tx_msg_q, tx_msg_d;
  logic       valid_q, valid_d;
  logic [2:0] msginfo_q, msginfo_d;
  logic       detector_en_q, detector_en_d;
  logic       end_q, end_d;

  logic [NUM_LANES-1:0] lane_pass;
  logic                 lane_clear;
  logic                 lane_count_en;

`ifdef REPAIRCLK_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_expire;
  logic            timeout_q, timeout_d;

  // Watchdog runs while the handshake is in progress and restarts from IDLE.
  always_comb begin
    to_cnt_d  = '0;
    to_expire = 1'b0;
    if ((state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_TIMEOUT)) begin
      to_expire = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
      to_cnt_d  = to_cnt_q + TO_W'(1);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:          if (i_MBINIT_CAL_end)                state_d = ST_WAIT_INIT_REQ;
      ST_WAIT_INIT_REQ: if (i_RX_SbMessage == INIT_REQ)     state_d = ST_HOLD_INIT;
      ST_HOLD_INIT:     if (!i_Busy_SideBand)                state_d = ST_INIT_RESP;
      ST_INIT_RESP:     if (i_falling_edge_busy)             state_d = ST_DETECT;
      ST_DETECT:        if (i_RX_SbMessage == RESULT_REQ)   state_d = ST_HOLD_RESULT;
      ST_HOLD_RESULT:   if (!i_Busy_SideBand)                state_d = ST_RESULT_RESP;
      ST_RESULT_RESP:   if (i_falling_edge_busy)             state_d = ST_WAIT_DONE_REQ;
      ST_WAIT_DONE_REQ: if (i_RX_SbMessage == DONE_REQ)     state_d = ST_HOLD_DONE;
      ST_HOLD_DONE:     if (!i_Busy_SideBand)                state_d = ST_DONE_RESP;
      ST_DONE_RESP:     if (i_falling_edge_busy)             state_d = ST_DONE;
      ST_DONE:          state_d = ST_DONE;
`ifdef REPAIRCLK_TIMEOUT_EN
      ST_TIMEOUT:       state_d = ST_TIMEOUT;
`endif
      default:          state_d = ST_IDLE;
    endcase

`ifdef REPAIRCLK_TIMEOUT_EN
    if (to_expire) begin
      state_d = ST_TIMEOUT;
    end
`endif

    // Losing the CAL-stage enable aborts from anywhere, taking priority.
    if ((state_q != ST_IDLE) && !i_MBINIT_CAL_end) begin
      state_d = ST_IDLE;
    end
  end

  // Outputs are decoded from the next state so they line up with state entry.
  always_comb begin
    tx_msg_d      = resp_code(state_d);
    valid_d       = is_resp_state(state_d);
    detector_en_d = (state_d == ST_DETECT);
    end_d         = (state_d == ST_DONE);
    msginfo_d     = msginfo_q;
    lane_clear    = (state_d == ST_IDLE);
`ifdef REPAIRCLK_TIMEOUT_EN
    timeout_d     = (state_d == ST_TIMEOUT);
    if (state_d == ST_TIMEOUT) begin
      lane_clear = 1'b1;
    end
`endif
    if (lane_clear) begin
      msginfo_d = 3'b000;
    end else if ((state_q == ST_DETECT) && (state_d == ST_HOLD_RESULT)) begin
      msginfo_d = lane_pass;
    end
  end

  assign lane_count_en = (state_q == ST_DETECT);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    repairclk_lane_counter #(
      .PASS_THRESHOLD(PASS_THRESHOLD)
    ) u_lane_counter (
      .CLK     (CLK),
      .rst     (rst),
      .clear   (lane_clear),
      .count_en(lane_count_en),
      .hit     (i_pattern_hit[g]),
      .miss    (i_pattern_miss[g]),
      .pass    (lane_pass[g])
    );
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tx_msg_q      <= 4'h0;
      valid_q       <= 1'b0;
      msginfo_q     <= 3'b000;
      detector_en_q <= 1'b0;
      end_q         <= 1'b0;
`ifdef REPAIRCLK_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      tx_msg_q      <= tx_msg_d;
      valid_q       <= valid_d;
      msginfo_q     <= msginfo_d;
      detector_en_q <= detector_en_d;
      end_q         <= end_d;
`ifdef REPAIRCLK_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign o_TX_SbMessage                       = tx_msg_q;
  assign o_ValidOutData_ModulePartner         = valid_q;
  assign o_msginfo                            = msginfo_q;
  assign o_detector_en                        = detector_en_q;
  assign o_MBINIT_REPAIRCLK_ModulePartner_end = end_q;
`ifdef REPAIRCLK_TIMEOUT_EN
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_repairclk_module_partner.sv
// Directed testbench for repairclk_module_partner; output bundle layout is
// {tx[3:0], valid, msginfo[2:0], detector_en, end, timeout}.
module tb_repairclk_module_partner;

  logic       CLK = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] rx = 4'h0;
  logic       busy = 1'b0;
  logic       fall = 1'b0;
  logic [2:0] hit = 3'b000;
  logic [2:0] miss = 3'b000;

  logic [3:0] o_TX_SbMessage;
  logic       o_ValidOutData_ModulePartner;
  logic [2:0] o_msginfo;
  logic       o_detector_en;
  logic       o_end;
  logic       o_timeout;

  int vectors = 0;
  int miscompares = 0;

  wire [10:0] outs = {o_TX_SbMessage, o_ValidOutData_ModulePartner, o_msginfo,
                      o_detector_en, o_end, o_timeout};

  repairclk_module_partner #(
    .PASS_THRESHOLD(16),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .CLK                                 (CLK),
    .rst                                 (rst),
    .i_MBINIT_CAL_end                    (en),
    .i_RX_SbMessage                      (rx),
    .i_Busy_SideBand                     (busy),
    .i_falling_edge_busy                 (fall),
    .i_pattern_hit                       (hit),
    .i_pattern_miss                      (miss),
    .o_TX_SbMessage                      (o_TX_SbMessage),
    .o_ValidOutData_ModulePartner        (o_ValidOutData_ModulePartner),
    .o_msginfo                           (o_msginfo),
    .o_detector_en                       (o_detector_en),
    .o_MBINIT_REPAIRCLK_ModulePartner_end(o_end),
    .o_timeout                           (o_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic to_idle();
    en = 1'b0; rx = 4'h0; busy = 1'b0; fall = 1'b0; hit = 3'b000; miss = 3'b000;
    tick(1);
  endtask

  // IDLE -> WAIT_INIT_REQ -> HOLD_INIT -> INIT_RESP -> DETECT with busy low.
  task automatic to_detect();
    en = 1'b1;
    tick(1);
    rx = 4'h1;
    tick(1);
    rx = 4'h0;
    tick(1);
    fall = 1'b1;
    tick(1);
    fall = 1'b0;
  endtask

  task automatic pulses(input logic [2:0] h, input logic [2:0] m, input int n);
    hit = h; miss = m;
    tick(n);
    hit = 3'b000; miss = 3'b000;
  endtask

  // DETECT -> HOLD_RESULT -> RESULT_RESP
  task automatic request_result();
    rx = 4'h3;
    tick(1);
    rx = 4'h0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vectors++;
    if (outs !== 11'h000) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got %h expected %h", outs, 11'h000);
    end
    en = 1'b1;
    tick(2);
    vectors++;
    if (outs !== 11'h000) begin
      miscompares++;
      $display("[TB] FAIL reset_held: got %h expected %h", outs, 11'h000);
    end
    rst = 1'b0;
    en = 1'b0;
    tick(1);
  endtask

  task automatic test_all_pass();
    logic [10:0] exp;
    to_idle();
    en = 1'b1;
    tick(1);
    vectors++;
    if (outs !== 11'h000) begin
      miscompares++;
      $display("[TB] FAIL wait_init_quiet: got %h expected %h", outs, 11'h000);
    end
    rx = 4'h1;
    tick(1);
    rx = 4'h0;
    tick(1);
    exp = {4'h2, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("[TB] FAIL init_resp: got %h expected %h", outs, exp);
    end
    fall = 1'b1;
    tick(1);
    fall = 1'b0;
    exp = {4'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("[TB] FAIL detect_entry: got %h expected %h", outs, exp);
    end
    pulses(3'b111, 3'b000, 20);
    rx = 4'h3;
    tick(1);
    rx = 4'h0;
    exp = {4'h0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("[TB] FAIL hold_result_latch: got %h expected %h", outs, exp);
    end
    tick(1);
    exp = {4'h4, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("[TB] FAIL result_resp_all_pass: got %h expected %h", outs, exp);
    end
  endtask

  task automatic test_rckn_fail();
    logic [10:0] exp;
    to_idle();
    to_detect();
    pulses(3'b111, 3'b000, 15);
    pulses(3'b101, 3'b010, 1);
    pulses(3'b111, 3'b000, 10);
    request_result();
    exp = {4'h4, 1'b1, 3'b101, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("[TB] FAIL rckn_miss_restart: got %h expected %h", outs, exp);
    end
  endtask

  // RTRK stops at 15, RCKN saturates then shrugs off misses, RCKP sees hit+miss.
  task automatic test_threshold();
    logic [10:0] exp;
    to_idle();
    to_detect();
    pulses(3'b111, 3'b000, 10);
    pulses(3'b001, 3'b001, 1);
    pulses(3'b111, 3'b000, 5);
    pulses(3'b010, 3'b000, 3);
    pulses(3'b000, 3'b010, 1);
    pulses(3'b010, 3'b010, 1);
    rx = 4'h5;
    tick(1);
    rx = 4'h1;
    tick(1);
    rx = 4'h0;
    exp = {4'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("[TB] FAIL detect_ignores_codes: got %h expected %h", outs, exp);
    end
    request_result();
    exp = {4'h4, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("[TB] FAIL threshold_edges: got %h expected %h", outs, exp);
    end
  endtask

  task automatic test_no_hits();
    logic [10:0] exp;
    to_idle();
    to_detect();
    request_result();
    exp = {4'h4, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("[TB] FAIL no_hits_result: got %h expected %h", outs, exp);
    end
  endtask

  task automatic test_busy_hold();
    logic [10:0] exp;
    to_idle();
    en = 1'b1;
    tick(1);
    busy = 1'b1;
    rx = 4'h1;
    tick(1);
    rx = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      vectors++;
      if (o_ValidOutData_ModulePartner !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL busy_hold_valid cycle %0d: got %b expected 0", i, o_ValidOutData_ModulePartner);
      end
    end
    busy = 1'b0;
    tick(1);
    exp = {4'h2, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("[TB] FAIL busy_release: got %h expected %h", outs, exp);
    end
  endtask

  task automatic test_drop_enable();
    logic [10:0] exp;
    to_idle();
    to_detect();
    pulses(3'b111, 3'b000, 16);
    request_result();
    exp = {4'h4, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("[TB] FAIL exact_threshold: got %h expected %h", outs, exp);
    end
    en = 1'b0;
    tick(1);
    vectors++;
    if (outs !== 11'h000) begin
      miscompares++;
      $display("[TB] FAIL drop_enable: got %h expected %h", outs, 11'h000);
    end
    en = 1'b1;
    tick(1);
    rx = 4'h3;
    tick(1);
    rx = 4'h0;
    tick(1);
    vectors++;
    if (outs !== 11'h000) begin
      miscompares++;
      $display("[TB] FAIL wait_ignores_result_req: got %h expected %h", outs, 11'h000);
    end
  endtask

  task automatic test_done();
    logic [10:0] exp;
    to_idle();
    to_detect();
    request_result();
    fall = 1'b1;
    tick(1);
    fall = 1'b0;
    vectors++;
    if (outs !== 11'h000) begin
      miscompares++;
      $display("[TB] FAIL wait_done_quiet: got %h expected %h", outs, 11'h000);
    end
    rx = 4'h5;
    tick(1);
    rx = 4'h0;
    tick(1);
    exp = {4'h6, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("[TB] FAIL done_resp: got %h expected %h", outs, exp);
    end
    fall = 1'b1;
    tick(1);
    fall = 1'b0;
    rx = 4'h1;
    tick(1);
    rx = 4'h3;
    tick(1);
    rx = 4'h0;
    tick(3);
    exp = {4'h0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0};
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("[TB] FAIL done_held: got %h expected %h", outs, exp);
    end
    en = 1'b0;
    tick(1);
    vectors++;
    if (outs !== 11'h000) begin
      miscompares++;
      $display("[TB] FAIL done_exit: got %h expected %h", outs, 11'h000);
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] exp;
    to_idle();
    to_detect();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (outs !== 11'h000) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_cycle: got %h expected %h", outs, 11'h000);
    end
    tick(1);
    rst = 1'b0;
    tick(1);
    rx = 4'h1;
    tick(1);
    rx = 4'h0;
    tick(1);
    exp = {4'h2, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("[TB] FAIL restart_after_reset: got %h expected %h", outs, exp);
    end
  endtask

`ifdef REPAIRCLK_TIMEOUT_EN
  task automatic test_timeout();
    logic [10:0] exp;
    to_idle();
    en = 1'b1;
    tick(50);
    vectors++;
    if (o_timeout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_early: got %b expected 0", o_timeout);
    end
    tick(1);
    exp = {4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("[TB] FAIL timeout_fire: got %h expected %h", outs, exp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_pass();
    test_rckn_fail();
    test_threshold();
    test_no_hits();
    test_busy_hold();
    test_drop_enable();
    test_done();
    test_async_reset();
`ifdef REPAIRCLK_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
